// File: rtl/wgt_loader.sv
// wgt_loader: packs 9-byte 3x3 kernels into three row words and issues them on request.
module wgt_loader #(
    parameter int DATA_W = 8,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_kernels,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    input  logic                     next_req,
    output logic signed [WORD_W-1:0] wgt_word [2:0],
    output logic                     wgt_read,
    output logic                     busy,
    output logic                     done
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] ISSUE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    logic [2:0]                state_q, state_d;
    logic [3:0]                byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]          kern_left_q, kern_left_d;
    logic [DATA_W-1:0]         fill_q [9];
    logic [DATA_W-1:0]         fill_d [9];
    logic signed [WORD_W-1:0]  wgt_q [2:0];
    logic signed [WORD_W-1:0]  wgt_d [2:0];
    logic                      wgt_read_q, wgt_read_d;
    logic                      take;
    assign take     = (state_q == FILL) && s_valid;
    assign s_ready  = state_q == FILL;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign wgt_read = wgt_read_q;
    assign wgt_word = wgt_q;
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = take ? byte_cnt_q + 4'd1 : byte_cnt_q;
        kern_left_d = kern_left_q;
        fill_d      = fill_q;
        wgt_d       = wgt_q;
        wgt_read_d  = 1'b0;
        if (take) fill_d[byte_cnt_q] = s_data;
        case (state_q)
            IDLE: if (start) begin
                kern_left_d = num_kernels;
                byte_cnt_d  = 4'd0;
                state_d     = (num_kernels == '0) ? DONE : FILL;
            end
            FILL: state_d = (take && byte_cnt_q == 4'd8) ? WAIT : FILL;
            WAIT: if (next_req) begin
                state_d    = ISSUE;
                wgt_read_d = 1'b1;
                for (int i = 0; i < 3; i++)
                    wgt_d[i] = WORD_W'({fill_q[3*i], fill_q[3*i+1], fill_q[3*i+2]});
            end
            ISSUE: begin
                kern_left_d = kern_left_q - CNT_W'(1);
                byte_cnt_d  = 4'd0;
                state_d     = (kern_left_q == CNT_W'(1)) ? DONE : FILL;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            kern_left_q <= '0;
            fill_q      <= '{default: '0};
            wgt_q       <= '{default: '0};
            wgt_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            kern_left_q <= kern_left_d;
            fill_q      <= fill_d;
            wgt_q       <= wgt_d;
            wgt_read_q  <= wgt_read_d;
        end
    end
endmodule

// File: tb/tb_wgt_loader.sv
// tb_wgt_loader: directed job sequence with random bytes, checked against a byte-queue packing model.
module tb_wgt_loader;
    logic               clk = 1'b0;
    logic               rst, start, s_valid, s_ready, next_req, wgt_read, busy, done;
    logic [7:0]         num_kernels, s_data;
    logic signed [31:0] wgt_word [2:0];
    int                 n_pass = 0, n_tot = 0, rd_cnt = 0, done_cnt = 0;
    logic [7:0]         kb [9];
    logic [31:0]        prev [3];

    wgt_loader dut (
        .clk(clk), .rst(rst), .start(start), .num_kernels(num_kernels),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .next_req(next_req),
        .wgt_word(wgt_word), .wgt_read(wgt_read), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (wgt_read) rd_cnt++;
        if (done) done_cnt++;
    endtask

    // Row w holds bytes 3w,3w+1,3w+2 from high lane to low lane, top byte zero.
    function automatic logic [31:0] word_of(input int w);
        return 32'(kb[3*w]) * 65536 + 32'(kb[3*w+1]) * 256 + 32'(kb[3*w+2]);
    endfunction

    // mode 0: ramp base+16*kernel+k, 1: random, 2: constant base
    task automatic job(input int n, input int mode, input logic [7:0] base, input bit bubble,
                       input bit hold, input int dly, input bit poke);
        start = 1'b1; num_kernels = 8'(n); next_req = hold;
        cyc();
        start = 1'b0; rd_cnt = 0; done_cnt = 0;
        chk("start_busy", busy, 1);
        if (n == 0) begin
            chk("zero_done", done, 1);
            chk("zero_ready", s_ready, 0);
            cyc();
            chk("zero_done_end", done, 0);
            chk("zero_idle", busy, 0);
            chk("zero_reads", rd_cnt, 0);
            return;
        end
        for (int kk = 0; kk < n; kk++) begin
            int  k = 0, g = 0;
            bit  v = 1'b1, poked = 1'b0;
            for (int i = 0; i < 9; i++)
                kb[i] = mode == 1 ? 8'($urandom) : mode == 2 ? base : 8'(base + 16 * kk + i);
            while (k < 9 && g < 60) begin
                g++;
                chk("fill_ready", s_ready, 1);
                if (poke && k == 3 && !poked) begin
                    poked = 1'b1; start = 1'b1; num_kernels = 8'd5; next_req = 1'b1; s_valid = 1'b0;
                    cyc();
                    start = 1'b0; next_req = hold;
                    continue;
                end
                s_valid = v;
                s_data  = v ? kb[k] : 8'($urandom);
                cyc();
                if (v) k++;
                if (bubble) v = !v;
            end
            chk("fill_count", k, 9);
            s_valid = 1'b0;
            chk("wait_ready", s_ready, 0);
            chk("wait_read", wgt_read, 0);
            for (int w = 0; w < 3; w++) chk("wait_hold", wgt_word[w], prev[w]);
            if (!hold) begin
                for (int i = 0; i < dly; i++) begin
                    s_valid = 1'b1; s_data = 8'($urandom); next_req = 1'b0;
                    cyc();
                    chk("wait_ready_d", s_ready, 0);
                    chk("wait_noread", wgt_read, 0);
                    for (int w = 0; w < 3; w++) chk("wait_hold_d", wgt_word[w], prev[w]);
                end
            end
            next_req = 1'b1;
            cyc();
            chk("issue_read", wgt_read, 1);
            chk("issue_ready", s_ready, 0);
            for (int w = 0; w < 3; w++) begin
                chk("issue_word", wgt_word[w], word_of(w));
                prev[w] = word_of(w);
            end
            next_req = hold;
            cyc();
            chk("post_read", wgt_read, 0);
            if (kk == n - 1) chk("last_done", done, 1);
            else chk("next_fill", s_ready, 1);
        end
        s_valid = 1'b0; next_req = 1'b0;
        cyc();
        chk("end_done", done, 0);
        chk("end_idle", busy, 0);
        chk("read_pulses", rd_cnt, n);
        chk("done_pulses", done_cnt, 1);
        for (int w = 0; w < 3; w++) chk("persist", wgt_word[w], prev[w]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_kernels = 8'd0; s_valid = 1'b0; s_data = 8'd0; next_req = 1'b0;
        for (int w = 0; w < 3; w++) prev[w] = 32'd0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", wgt_read, 0);
        for (int w = 0; w < 3; w++) chk("rst_word", wgt_word[w], 0);
        job(1, 0, 8'h01, 1'b0, 1'b1, 0, 1'b0);
        job(1, 0, 8'h01, 1'b1, 1'b1, 0, 1'b0);
        job(3, 0, 8'h10, 1'b0, 1'b0, 5, 1'b0);
        job(0, 0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        // Abort a job after four bytes, with a start pulse that reset must override.
        start = 1'b1; num_kernels = 8'd1;
        cyc();
        start = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 8'($urandom);
            cyc();
        end
        s_valid = 1'b0; rst = 1'b1; start = 1'b1;
        cyc();
        rst = 1'b0; start = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", s_ready, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_read", wgt_read, 0);
        for (int w = 0; w < 3; w++) begin
            chk("mid_rst_word", wgt_word[w], 0);
            prev[w] = 32'd0;
        end
        job(1, 0, 8'hA1, 1'b0, 1'b0, 0, 1'b0);
        job(1, 2, 8'hFF, 1'b0, 1'b0, 2, 1'b1);
        job(4, 1, 8'h00, 1'b1, 1'b0, 1, 1'b0);
        job(255, 1, 8'h00, 1'b0, 1'b1, 0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
